// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the peripheral register window: base address, word offsets, TCON bits.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package peripheral_bus_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h4000_0000;

    // Word offsets inside the 32-byte window (byte address bits [4:2])
    typedef enum logic [2:0] {
        ADDR_TH      = 3'd0,
        ADDR_TL      = 3'd1,
        ADDR_TCON    = 3'd2,
        ADDR_LED     = 3'd3,
        ADDR_SWITCH  = 3'd4,
        ADDR_DIGI    = 3'd5,
        ADDR_SYSTICK = 3'd6,
        ADDR_RSVD    = 3'd7
    } reg_off_e;

    localparam int TCON_W   = 3;
    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_IRQ = 2;

    // True when a byte address falls inside the 32-byte window at base
    function automatic logic win_hit(input logic [31:0] a, input logic [31:0] base);
        return a[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// Load/store port between the datapath memory mux and the peripheral window.
// Latency: reads combinational, writes commit on the clock edge.
// Backpressure: none; every access completes in its own cycle.
interface peripheral_bus_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/peripheral_bus_timer_core.sv
// Reloadable 32-bit up-counter (TH reload, TL count) with sticky overflow interrupt.
// Latency: register writes and count/reload take effect on the next edge.
// Backpressure: none; CPU writes always win over the same-cycle count event.
module timer_core
    import peripheral_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_th,
    input  logic              wr_tl,
    input  logic              wr_tcon,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon
);

    logic overflow;
    logic irq_set;

    // Overflow fires on the edge where an enabled counter sits at all-ones;
    // a CPU write to TL in that cycle cancels the whole reload event.
    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign irq_set  = overflow && tcon[TCON_IE] && !wr_tl;

    // Timer registers: CPU writes take priority, otherwise count/reload from the pre-edge TH
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end else if (tcon[TCON_EN]) begin
                tl <= overflow ? th : tl + 32'd1;
            end
            if (wr_tcon) begin
                tcon <= wdata[TCON_W-1:0];
            end else if (irq_set) begin
                tcon[TCON_IRQ] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral window: timer, LED/7-seg outputs, synchronised switches, systick.
// Latency: read data combinational in the access cycle; writes commit on the edge.
// Backpressure: none; the bus is always ready, unmapped accesses read 0 and drop writes.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = peripheral_bus_pkg::BASE_ADDR,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    peripheral_bus_if.slave     bus,
    output logic [LED_W-1:0]    led,
    input  logic [SW_W-1:0]     switch,
    output logic [DIGI_W-1:0]   digi,
    output logic                irqout
);
    import peripheral_bus_pkg::*;

    logic              hit;
    logic              wen;
    reg_off_e          off;
    logic              unused_addr_lsb;
    logic [31:0]       th;
    logic [31:0]       tl;
    logic [TCON_W-1:0] tcon;
    logic [31:0]       systick;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;

    // Word access only: the byte lane bits are deliberately ignored
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign hit    = win_hit(bus.addr, BASE_ADDR);
    assign off    = reg_off_e'(bus.addr[4:2]);
    assign wen    = bus.wr && hit;
    assign irqout = tcon[TCON_IRQ];

    timer_core u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wen && (off == ADDR_TH)),
        .wr_tl   (wen && (off == ADDR_TL)),
        .wr_tcon (wen && (off == ADDR_TCON)),
        .wdata   (bus.wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon)
    );

    // Output registers, free-running systick and the two-flop switch synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            if (wen && (off == ADDR_LED)) begin
                led <= bus.wdata[LED_W-1:0];
            end
            if (wen && (off == ADDR_DIGI)) begin
                digi <= bus.wdata[DIGI_W-1:0];
            end
            systick <= systick + 32'd1;
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    // Read mux: pre-edge register state, zero-extended, zero when idle or outside the window
    always_comb begin
        bus.rdata = '0;
        if (bus.rd && hit) begin
            case (off)
                ADDR_TH:      bus.rdata = th;
                ADDR_TL:      bus.rdata = tl;
                ADDR_TCON:    bus.rdata = {{(32-TCON_W){1'b0}}, tcon};
                ADDR_LED:     bus.rdata = {{(32-LED_W){1'b0}}, led};
                ADDR_SWITCH:  bus.rdata = {{(32-SW_W){1'b0}}, sw_sync};
                ADDR_DIGI:    bus.rdata = {{(32-DIGI_W){1'b0}}, digi};
                ADDR_SYSTICK: bus.rdata = systick;
                default:      bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus: expectations are queued by the stimulus and
// drained by a monitor that samples DUT outputs on the falling edge.
module tb_peripheral_bus;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TICK = 32'h4000_0018;
    localparam logic [31:0] A_RSVD = 32'h4000_001C;

    localparam int K_RDATA = 0;
    localparam int K_LED   = 1;
    localparam int K_DIGI  = 2;
    localparam int K_IRQ   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    peripheral_bus_if bus ();

    peripheral_bus #(
        .BASE_ADDR (32'h4000_0000),
        .LED_W     (8),
        .SW_W      (8),
        .DIGI_W    (12)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .led    (led),
        .switch (switch),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    // Scoreboard queues
    int          q_kind[$];
    logic [31:0] q_val[$];
    string       q_name[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        obs_vld = 1'b0;
    logic [31:0] systick_m = '0;

    int          mon_k;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    string       mon_nm;

    // Monitor: drain every queued expectation when the stimulus marks a sample point
    always @(negedge clk) begin
        if (obs_vld) begin
            while (q_kind.size() > 0) begin
                mon_k   = q_kind.pop_front();
                mon_exp = q_val.pop_front();
                mon_nm  = q_name.pop_front();
                case (mon_k)
                    K_RDATA: mon_act = bus.rdata;
                    K_LED:   mon_act = {24'h0, led};
                    K_DIGI:  mon_act = {20'h0, digi};
                    default: mon_act = {31'h0, irqout};
                endcase
                n_cmp++;
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", mon_nm, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        if (!reset) systick_m = systick_m + 32'd1;
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.rd    = r;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic expect_v(input int k, input logic [31:0] v, input string nm);
        q_kind.push_back(k);
        q_val.push_back(v);
        q_name.push_back(nm);
    endtask

    task automatic sample();
        obs_vld = 1'b1;
        @(negedge clk);
        #1;
        obs_vld = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
        step();
        drive(1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] v, input string nm);
        drive(1'b1, 1'b0, a, 32'h0);
        expect_v(K_RDATA, v, nm);
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two edges while a LED write is attempted
        reset  = 1'b1;
        switch = 8'h00;
        drive(1'b0, 1'b1, A_LED, 32'hFFFF_FFFF);
        step();
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, A_TICK, 32'h0);
        expect_v(K_LED, 32'h0, "rst_led");
        expect_v(K_DIGI, 32'h0, "rst_digi");
        expect_v(K_IRQ, 32'h0, "rst_irq");
        expect_v(K_RDATA, 32'h0, "rst_systick");
        sample();
        step();
        for (int i = 0; i < 6; i++) begin
            read_chk(A_TH + 32'(i * 4), 32'h0, "rst_reg");
            step();
        end

        // Timer reload and sticky interrupt
        write(A_TH, 32'hFFFF_FFFD);
        write(A_TL, 32'hFFFF_FFFE);
        write(A_TCON, 32'h3);
        read_chk(A_TL, 32'hFFFF_FFFE, "tl_pre");
        step();
        expect_v(K_IRQ, 32'h0, "irq_pre");
        read_chk(A_TL, 32'hFFFF_FFFF, "tl_max");
        step();
        expect_v(K_IRQ, 32'h1, "irq_set");
        read_chk(A_TL, 32'hFFFF_FFFD, "tl_reload");
        step();
        step();
        expect_v(K_IRQ, 32'h1, "irq_sticky");
        read_chk(A_TL, 32'hFFFF_FFFF, "tl_max2");
        write(A_TCON, 32'h3);
        expect_v(K_IRQ, 32'h0, "irq_clear");
        read_chk(A_TCON, 32'h3, "tcon_rw");
        step();
        read_chk(A_TL, 32'hFFFF_FFFE, "tl_after_clear");
        write(A_TCON, 32'h0);
        read_chk(A_TL, 32'hFFFF_FFFF, "tl_stop");
        step();
        read_chk(A_TL, 32'hFFFF_FFFF, "tl_hold");

        // Collisions in the overflow cycle
        write(A_TCON, 32'h3);
        write(A_TL, 32'h10);
        expect_v(K_IRQ, 32'h0, "irq_tl_coll");
        read_chk(A_TL, 32'h10, "tl_coll");
        step();
        write(A_TL, 32'hFFFF_FFFF);
        write(A_TCON, 32'h1);
        expect_v(K_IRQ, 32'h0, "irq_tcon_coll");
        read_chk(A_TCON, 32'h1, "tcon_coll");
        step();
        step();
        write(A_TH, 32'h1234);
        read_chk(A_TL, 32'hFFFF_FFFD, "th_coll_reload");
        write(A_TCON, 32'h0);
        read_chk(A_TH, 32'h1234, "th_new");
        step();

        // LED, DIGI, systick
        write(A_LED, 32'h1A5);
        expect_v(K_LED, 32'hA5, "led_out");
        read_chk(A_LED, 32'hA5, "led_rd");
        step();
        write(A_DIGI, 32'hFFFF_FFFF);
        expect_v(K_DIGI, 32'hFFF, "digi_out");
        read_chk(A_DIGI, 32'hFFF, "digi_rd");
        step();
        write(A_TICK, 32'h1234_5678);
        read_chk(A_TICK, systick_m, "systick");
        step();

        // Switch synchroniser latency
        switch = 8'h3C;
        read_chk(A_SW, 32'h0, "sw_n");
        step();
        read_chk(A_SW, 32'h0, "sw_n1");
        step();
        read_chk(A_SW, 32'h3C, "sw_n2");
        step();

        // Address decode
        read_chk(A_RSVD, 32'h0, "rsvd_rd");
        step();
        read_chk(32'h3000_0000, 32'h0, "miss_rd");
        step();
        write(32'h4000_0020, 32'h5555);
        read_chk(A_TH, 32'h1234, "miss_wr");
        step();
        write(A_SW, 32'h5555);
        read_chk(A_SW, 32'h3C, "ro_wr");
        step();
        drive(1'b0, 1'b0, A_LED, 32'h0);
        expect_v(K_RDATA, 32'h0, "rd_low");
        sample();
        step();

        // Simultaneous read and write
        drive(1'b1, 1'b1, A_LED, 32'h3C);
        expect_v(K_RDATA, 32'hA5, "rdwr_old");
        sample();
        step();
        drive(1'b0, 1'b0, A_LED, 32'h0);
        expect_v(K_LED, 32'h3C, "rdwr_led");
        read_chk(32'h4000_000F, 32'h3C, "rdwr_new_lsb");
        step();

        n_cmp++;
        if (q_kind.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", q_kind.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peripheral_bus.md
Name: peripheral_bus

Overview:
Memory-mapped peripheral block downstream of the execute-stage ALU. The ALU result Z is the load/store address. The data-memory mux routes accesses in the 0x4000_0000 window here. Holds a reloadable timer with interrupt, LED/7-segment output registers, synchronised switch inputs and a free-running systick. Read data returns to the writeback mux in the same cycle; writes commit on the clock edge.

Parameters:
BASE_ADDR, 32'h4000_0000, base of the 32-byte register window (addr[31:5] compared)
LED_W, 8, LED register width
SW_W, 8, switch input width
DIGI_W, 12, 7-segment drive register width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rd  in  1  memory read strobe (MemRead)
wr  in  1  memory write strobe (MemWrite)
addr  in  32  byte address from ALU Z
wdata  in  32  store data (rt operand)
rdata  out  32  read data, combinational
led  out  LED_W  LED register
switch  in  SW_W  asynchronous board switches
digi  out  DIGI_W  7-segment register
irqout  out  1  timer interrupt request (TCON[2])

Behaviour:
- Hit = addr[31:5]==BASE_ADDR[31:5]. addr[1:0] ignored (word access). Offset = addr[4:2].
- Register map:
  - 0x00 TH rw 32
  - 0x04 TL rw 32
  - 0x08 TCON rw 3 (bit0 enable, bit1 irq-enable, bit2 irq-status)
  - 0x0C LED rw
  - 0x10 SWITCH ro
  - 0x14 DIGI rw
  - 0x18 SYSTICK ro
  - 0x1C reserved
- Reset (sync, next edge with reset=1):
  - TH=TL=0, TCON=0, led=0, digi=0, systick=0, switch sync flops=0.
  - irqout=0.
  - Reset wins over every concurrent write or count.
- Write: on an edge with wr=1 and hit, the addressed rw register takes wdata, truncated to its width.
  - Writes to ro, reserved or unmapped addresses are ignored.
  - wr outside the window is ignored.
- Read: rdata = register value when rd=1 and hit, else 32'h0.
  - Narrow registers are zero-extended.
  - Reserved offset reads 0.
  - Read returns pre-edge state. A same-cycle write is visible the next cycle.
- Timer, per edge with TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
  - Otherwise TL<=TL+1.
  - TCON[0]=0 holds TL; TCON[2] is unchanged.
- TCON[2] is sticky. It is cleared only by a software write of 0 to bit2, or by reset. irqout = TCON[2].
- Simultaneous events:
  - A CPU write to TL beats the count/reload in the same cycle.
  - A CPU write to TCON replaces all 3 bits, overriding a same-cycle overflow set.
  - A write to TH in the overflow cycle: the reload uses the old TH.
- SYSTICK increments every non-reset edge. It wraps 0xFFFF_FFFF→0.
- SWITCH passes through a 2-flop synchroniser. A read reflects the pin value sampled 2 edges earlier.
- rd and wr both high: the write commits and rdata still shows the old value.

Decomposition:
- Shared package constants:
  - offsets ADDR_TH..ADDR_SYSTICK
  - TCON bit indices TCON_EN, TCON_IE, TCON_IRQ
  - BASE_ADDR
- One sub-module, timer_core: TH/TL/TCON registers, write port and reload/irq logic.
- peripheral_bus keeps the address decode, read mux, LED/DIGI/SYSTICK and the switch synchroniser.

Test Plan:
- Reset: assert reset 2 cycles with wr=1, wdata=all-ones, addr=0x4000_000C → led=0, irqout=0, every register reads 0 after release.
- Timer reload + irq:
  - Setup: write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, then TCON=3.
  - First edge after TCON write: TL=0xFFFF_FFFF.
  - Second edge: TL=0xFFFF_FFFD, irqout=1.
  - Two edges later: TL=0xFFFF_FFFF.
  - Write TCON=3 → irqout=0 next cycle.
- Collision: TL=0xFFFF_FFFF with timer enabled, write TL=0x10 in the overflow cycle → TL=0x10 and irqout stays 0. Repeat writing TCON=1 in the overflow cycle → irqout=0.
- LED/DIGI:
  - Write 0x1A5 to 0x4000_000C → led=0xA5, read 0x0000_00A5.
  - Write 0xFFFF_FFFF to 0x4000_0014 → digi=0xFFF.
  - Write to 0x4000_0018 → systick continues counting unaffected.
- Switch latency: drive switch=0x3C at edge n → reads at 0x4000_0010 return 0 through edge n+1, then 0x3C from edge n+2.
- Decode:
  - Read 0x4000_001C or 0x3000_0000 → rdata=0.
  - Write 0x5555 to 0x4000_0020 → no register changes.
  - rd=0 with a hit → rdata=0.
